// File: rtl/stripe_n_if.sv
// Bundle of the word-in / lanes-out signals of stripe_n.
// The producer (master) drives the input word; stripe_n (slave) drives the lanes.
interface stripe_n_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  // valid_in qualifies data_in on every rising clk_2f edge; there is no backpressure.
  // lane_valid[i] marks a fresh word on lane i for exactly one cycle.
  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic [$clog2(LANES):0]  num_lanes;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES-1:0]        lane_valid;
  logic                    burst_end;
  logic [15:0]             burst_len;
  logic                    dbg_state;

  modport master (
    output data_in, valid_in, num_lanes,
    input  lane_data, lane_valid, burst_end, burst_len, dbg_state
  );

  modport slave (
    input  data_in, valid_in, num_lanes,
    output lane_data, lane_valid, burst_end, burst_len, dbg_state
  );
endinterface

// File: rtl/stripe_n.sv
// Stripes a stream of words round-robin across LANES output lanes with one cycle
// of latency, and reports the length of each completed burst.
module stripe_n #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int IDLE_ZERO = 1
) (
  input logic        clk_2f,
  input logic        reset,
  stripe_n_if.slave  bus
);
  localparam int PTR_W = $clog2(LANES);
  localparam int NL_W  = $clog2(LANES) + 1;
  localparam logic [NL_W-1:0] MAX_ACTIVE = NL_W'(LANES);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NL_W-1:0]         r_active;
  logic [NL_W-1:0]         w_active;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic [15:0]             r_cnt;
  logic [LANES*DATA_W-1:0] r_lane_data;
  logic [LANES-1:0]        r_lane_valid;
  logic                    r_burst_end;
  logic [15:0]             r_burst_len;
  logic [LANES-1:0]        w_sel;
  logic                    w_end;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_active <= MAX_ACTIVE;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active;
      r_ptr    <= w_ptr_nxt;
    end
  end

  // The lane count is sampled combinationally on IDLE cycles so the first word
  // of a burst already uses it; inside a burst the latched copy is frozen.
  always_comb begin
    w_active    = r_active;
    w_state_nxt = r_state;
    w_end       = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_sel       = '0;

    if (r_state == S_IDLE) begin
      if (bus.num_lanes == '0 || bus.num_lanes > MAX_ACTIVE) begin
        w_active = MAX_ACTIVE;
      end else begin
        w_active = bus.num_lanes;
      end
    end

    case (r_state)
      S_IDLE:  if (bus.valid_in)  w_state_nxt = S_BURST;
      S_BURST: if (!bus.valid_in) begin
        w_state_nxt = S_IDLE;
        w_end       = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (bus.valid_in) begin
      w_sel = LANES'(1) << r_ptr;
      if (NL_W'(r_ptr) >= w_active - NL_W'(1)) begin
        w_ptr_nxt = '0;
      end else begin
        w_ptr_nxt = r_ptr + PTR_W'(1);
      end
    end else if (w_end) begin
      w_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_lane_data  <= '0;
      r_lane_valid <= '0;
    end else begin
      r_lane_valid <= w_sel;
      for (int i = 0; i < LANES; i++) begin
        if (w_sel[i]) begin
          r_lane_data[i*DATA_W +: DATA_W] <= bus.data_in;
        end else if (IDLE_ZERO != 0) begin
          r_lane_data[i*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

  // Word counter saturates so an over-long burst reports 16'hFFFF, not a wrap.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_burst_end <= 1'b0;
      r_burst_len <= '0;
    end else begin
      r_burst_end <= w_end;
      if (w_end) begin
        r_burst_len <= r_cnt;
        r_cnt       <= '0;
      end else if (bus.valid_in && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.lane_data  = r_lane_data;
  assign bus.lane_valid = r_lane_valid;
  assign bus.burst_end  = r_burst_end;
  assign bus.burst_len  = r_burst_len;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_stripe_n.sv
// Directed bench for stripe_n (LANES=4, DATA_W=32, IDLE_ZERO=1): a table of
// per-cycle vectors plus hand sequences for reset mid-burst and saturation.
module tb_stripe_n;
  localparam int DW = 32;
  localparam int NL = 4;

  logic clk_2f;
  logic reset;

  stripe_n_if #(.DATA_W(DW), .LANES(NL)) bus ();

  stripe_n #(.DATA_W(DW), .LANES(NL), .IDLE_ZERO(1)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic [2:0]  nl;
    int          lane;
    logic        e_end;
    logic [15:0] e_len;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_fail;

  task automatic add(input logic vin, input logic [31:0] din, input logic [2:0] nl,
                     input int lane, input logic e_end, input logic [15:0] e_len);
    vec_t v;
    v.vin = vin; v.din = din; v.nl = nl; v.lane = lane; v.e_end = e_end; v.e_len = e_len;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic apply(input vec_t v);
    logic [3:0]   e_valid;
    logic [127:0] e_data;
    bus.valid_in  = v.vin;
    bus.data_in   = v.din;
    bus.num_lanes = v.nl;
    tick();
    e_valid = '0;
    e_data  = '0;
    if (v.lane >= 0) begin
      e_valid[v.lane]        = 1'b1;
      e_data[v.lane*32 +: 32] = v.din;
    end
    chk("lane_valid", 128'(bus.lane_valid), 128'(e_valid));
    chk("lane_data",  bus.lane_data, e_data);
    chk("burst_end",  128'(bus.burst_end), 128'(v.e_end));
    chk("burst_len",  128'(bus.burst_len), 128'(v.e_len));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.num_lanes = 3'd4;

    // Four lanes, eight words
    for (int i = 0; i < 8; i++) add(1'b1, 32'hA000_0000 + i, 3'd4, i % 4, 1'b0, 16'd0);
    add(1'b0, 32'd0, 3'd4, -1, 1'b1, 16'd8);
    add(1'b0, 32'd0, 3'd4, -1, 1'b0, 16'd8);
    // Two lanes, five words
    for (int i = 0; i < 5; i++) add(1'b1, 32'hB000_0000 + i, 3'd2, i % 2, 1'b0, 16'd8);
    add(1'b0, 32'd0, 3'd2, -1, 1'b1, 16'd5);
    add(1'b0, 32'd0, 3'd2, -1, 1'b0, 16'd5);
    // One-cycle gap splits the burst
    for (int i = 0; i < 3; i++) add(1'b1, 32'hC000_0000 + i, 3'd4, i, 1'b0, 16'd5);
    add(1'b0, 32'd0, 3'd4, -1, 1'b1, 16'd3);
    add(1'b1, 32'hC000_0003, 3'd4, 0, 1'b0, 16'd3);
    add(1'b0, 32'd0, 3'd4, -1, 1'b1, 16'd1);
    add(1'b0, 32'd0, 3'd4, -1, 1'b0, 16'd1);
    // num_lanes 4->1 mid-burst is ignored; next burst uses lane 0 only
    for (int i = 0; i < 6; i++) add(1'b1, 32'hD000_0000 + i, (i < 2) ? 3'd4 : 3'd1, i % 4, 1'b0, 16'd1);
    add(1'b0, 32'd0, 3'd1, -1, 1'b1, 16'd6);
    for (int i = 0; i < 3; i++) add(1'b1, 32'hE000_0000 + i, 3'd1, 0, 1'b0, 16'd6);
    add(1'b0, 32'd0, 3'd4, -1, 1'b1, 16'd3);
    add(1'b0, 32'd0, 3'd4, -1, 1'b0, 16'd3);
    // Out-of-range counts 0 and 7 act as 4; 3 lanes wraps after lane 2
    for (int i = 0; i < 5; i++) add(1'b1, 32'hF000_0000 + i, 3'd0, i % 4, 1'b0, 16'd3);
    add(1'b0, 32'd0, 3'd0, -1, 1'b1, 16'd5);
    for (int i = 0; i < 5; i++) add(1'b1, 32'hF100_0000 + i, 3'd7, i % 4, 1'b0, 16'd5);
    add(1'b0, 32'd0, 3'd7, -1, 1'b1, 16'd5);
    for (int i = 0; i < 7; i++) add(1'b1, 32'hF200_0000 + i, 3'd3, i % 3, 1'b0, 16'd5);
    add(1'b0, 32'd0, 3'd3, -1, 1'b1, 16'd7);
    add(1'b0, 32'd0, 3'd3, -1, 1'b0, 16'd7);

    // Reset state
    #12;
    chk("rst_lane_data",  bus.lane_data, 128'd0);
    chk("rst_lane_valid", 128'(bus.lane_valid), 128'd0);
    chk("rst_burst_end",  128'(bus.burst_end), 128'd0);
    chk("rst_burst_len",  128'(bus.burst_len), 128'd0);
    chk("rst_state",      128'(bus.dbg_state), 128'd0);
    @(negedge clk_2f);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-burst: three words, then reset drops between edges
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v.vin = 1'b1; v.din = 32'h5500_0000 + i; v.nl = 3'd4; v.lane = i; v.e_end = 1'b0; v.e_len = 16'd7;
      apply(v);
    end
    chk("burst_state", 128'(bus.dbg_state), 128'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_lane_data",  bus.lane_data, 128'd0);
    chk("arst_lane_valid", 128'(bus.lane_valid), 128'd0);
    chk("arst_burst_end",  128'(bus.burst_end), 128'd0);
    chk("arst_burst_len",  128'(bus.burst_len), 128'd0);
    chk("arst_state",      128'(bus.dbg_state), 128'd0);
    bus.valid_in = 1'b0;
    tick();
    chk("arst_hold_end", 128'(bus.burst_end), 128'd0);
    #2;
    reset = 1'b1;
    for (int i = 3; i < 6; i++) begin
      vec_t v;
      v.vin = 1'b1; v.din = 32'h5500_0000 + i; v.nl = 3'd4; v.lane = i - 3; v.e_end = 1'b0; v.e_len = 16'd0;
      apply(v);
    end
    begin
      vec_t v;
      v.vin = 1'b0; v.din = 32'd0; v.nl = 3'd4; v.lane = -1; v.e_end = 1'b1; v.e_len = 16'd3;
      apply(v);
    end

    // 70000-word burst saturates the length
    bus.valid_in  = 1'b1;
    bus.num_lanes = 3'd4;
    for (int i = 0; i < 70000; i++) begin
      bus.data_in = 32'(i);
      tick();
    end
    chk("sat_last_valid", 128'(bus.lane_valid), 128'(4'b1 << (69999 % 4)));
    bus.valid_in = 1'b0;
    tick();
    chk("sat_burst_end", 128'(bus.burst_end), 128'd1);
    chk("sat_burst_len", 128'(bus.burst_len), 128'hFFFF);
    tick();
    chk("sat_end_pulse", 128'(bus.burst_end), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/stripe_n.md
STRIPE_N -- requirements
Module: stripe_n

Interface
REQ-001 Parameter DATA_W, default 32, width of input word and of each lane.
REQ-002 Parameter LANES, default 4, number of output lanes; legal values 2, 4, 8.
REQ-003 Parameter IDLE_ZERO, default 1; 1 = a lane without a valid word drives 0, 0 = it holds its last data.
REQ-004 clk_2f  input  1  clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  DATA_W  word to stripe.
REQ-007 valid_in  input  1  data_in is valid this cycle.
REQ-008 num_lanes  input  $clog2(LANES)+1  number of active lanes requested.
REQ-009 lane_data  output  LANES*DATA_W  flat bus; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 lane_valid  output  LANES  bit i high = lane i carries a new word this cycle.
REQ-011 burst_end  output  1  one-cycle pulse marking the end of a burst.
REQ-012 burst_len  output  16  word count of the last completed burst.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and BURST.
REQ-014 IDLE->BURST SHALL occur on a cycle with valid_in=1; BURST->IDLE SHALL occur on a cycle with valid_in=0.
REQ-015 Active lane count SHALL be latched from num_lanes only on an IDLE cycle; values 0 or above LANES SHALL latch as LANES.
REQ-016 The first word of a burst SHALL use the num_lanes value present on that same cycle.
REQ-017 num_lanes changes during BURST SHALL be ignored until the next IDLE cycle.
REQ-018 Each accepted word SHALL go to the lane selected by the lane pointer.
REQ-019 After each accepted word, the pointer SHALL advance by 1 and wrap to 0 after active-1.
REQ-020 The pointer SHALL return to 0 on every BURST->IDLE transition, so every burst starts on lane 0.
REQ-021 Latency SHALL be one cycle: a word accepted at edge k appears on its lane with lane_valid high after edge k, until edge k+1.
REQ-022 Exactly one lane_valid bit SHALL be high per accepted word; all bits SHALL be 0 on cycles after valid_in=0.
REQ-023 Lanes at or above the active count SHALL never assert lane_valid; they SHALL drive 0 when IDLE_ZERO=1.
REQ-024 A lane with lane_valid low SHALL drive 0 if IDLE_ZERO=1, else hold its last data.
REQ-025 A burst word counter SHALL increment per accepted word and saturate at 16'hFFFF.
REQ-026 On BURST->IDLE, burst_len SHALL load the counter value, the counter SHALL clear, and burst_end SHALL pulse high for the following cycle.
REQ-027 A one-cycle valid_in gap SHALL end the current burst; the next valid word starts a new burst on lane 0 with a fresh count.
REQ-028 With active=1, every word SHALL go to lane 0.

Reset
REQ-029 While reset=0, asynchronously: lane_data=0, lane_valid=0, burst_end=0, burst_len=0, pointer=0, counter=0, FSM=IDLE, active count=LANES.
REQ-030 Reset asserted mid-burst SHALL discard the burst with no burst_end pulse.
REQ-031 After reset release, the first valid_in=1 cycle SHALL start a burst as in REQ-016.

Verification (LANES=4, DATA_W=32, IDLE_ZERO=1)
REQ-032 num_lanes=4, words A0..A7 on 8 consecutive cycles -> lanes 0,1,2,3,0,1,2,3 in order, one cycle late; then burst_end=1 and burst_len=8.
REQ-033 num_lanes=2, 5 words -> lanes 0,1,0,1,0; lanes 2-3 stay 0 with valid=0; burst_len=5.
REQ-034 Words W0,W1,W2, one-cycle gap, then W3 -> W3 on lane 0; burst_end pulses once with burst_len=3.
REQ-035 num_lanes changed 4->1 after the second of 6 words -> lane order 0,1,2,3,0,1; the next burst uses lane 0 only.
REQ-036 reset pulsed low after the 3rd of 6 words -> all outputs 0 immediately, no burst_end; the next burst starts on lane 0 with burst_len counted from 1.
REQ-037 num_lanes=0 or 7 -> behaves as 4 active lanes; 70000-word burst -> burst_len=16'hFFFF.
